// File: rtl/s100_ram_window.sv
// S-100 memory board model: synchronous RAM answering only inside a BASE_ADDR
// window, with a post-reset clear sequencer and selectable read latency.
module s100_ram_window #(
  parameter int                 ADDR_W         = 16,
  parameter int                 DATA_W         = 8,
  parameter int                 DEPTH_LOG2     = 12,
  parameter logic [ADDR_W-1:0]  BASE_ADDR      = 16'h0000,
  parameter bit                 CLEAR_ON_RESET = 1'b1,
  parameter int                 READ_LATENCY   = 1,
  parameter logic [DATA_W-1:0]  MISS_DATA      = 8'hFF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_enable,
  output logic              o_wr_ack,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_rd_enable,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_ready,
  output logic              o_rd_hit,
  output logic              o_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [DEPTH_LOG2-1:0]   clear_cnt_reg, clear_cnt_next;

  logic                    wr_hit, rd_hit;
  logic [DEPTH_LOG2-1:0]   wr_idx, rd_idx;
  logic                    wr_accept, rd_accept;
  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_waddr;
  logic [DATA_W-1:0]       mem_wdata;

  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DATA_W-1:0]       ram_q;
  logic                    rd_valid_a_reg;
  logic                    rd_hit_a_reg;
  logic                    wr_ack_reg;

  // Window decode; a window as wide as the bus matches every address.
  generate
    if (DEPTH_LOG2 >= ADDR_W) begin : g_full_window
      assign wr_hit = 1'b1;
      assign rd_hit = 1'b1;
    end else begin : g_part_window
      assign wr_hit = (i_wr_addr[ADDR_W-1:DEPTH_LOG2] == BASE_ADDR[ADDR_W-1:DEPTH_LOG2]);
      assign rd_hit = (i_rd_addr[ADDR_W-1:DEPTH_LOG2] == BASE_ADDR[ADDR_W-1:DEPTH_LOG2]);
    end
  endgenerate

  assign wr_idx = i_wr_addr[DEPTH_LOG2-1:0];
  assign rd_idx = i_rd_addr[DEPTH_LOG2-1:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      if (CLEAR_ON_RESET) state_reg <= ST_CLEAR;
      else                state_reg <= ST_IDLE;
      clear_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      clear_cnt_reg <= clear_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clear_cnt_next = clear_cnt_reg;
    wr_accept      = 1'b0;
    rd_accept      = 1'b0;
    mem_we         = 1'b0;
    mem_waddr      = wr_idx;
    mem_wdata      = i_wr_data;
    case (state_reg)
      ST_IDLE: begin
        wr_accept = i_wr_enable && wr_hit;
        rd_accept = i_rd_enable;
        mem_we    = wr_accept;
      end
      ST_CLEAR: begin
        // The sequencer owns the write port; bus requests are dropped.
        mem_we         = 1'b1;
        mem_waddr      = clear_cnt_reg;
        mem_wdata      = '0;
        clear_cnt_next = clear_cnt_reg + 1'b1;
        if (&clear_cnt_reg) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_busy = (state_reg == ST_CLEAR);

  // Read-first block RAM: a same-edge write is not visible to this read.
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_reset) mem[mem_waddr] <= mem_wdata;
    if (rd_accept && rd_hit && !i_reset) ram_q <= mem[rd_idx];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_valid_a_reg <= 1'b0;
      rd_hit_a_reg   <= 1'b0;
      wr_ack_reg     <= 1'b0;
    end else begin
      rd_valid_a_reg <= rd_accept;
      if (rd_accept) rd_hit_a_reg <= rd_hit;
      wr_ack_reg     <= wr_accept;
    end
  end

  assign o_wr_ack = wr_ack_reg;

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      logic seen_reg;

      // Until the first read completes, the data output shows its reset value.
      always_ff @(posedge i_clk) begin
        if (i_reset)        seen_reg <= 1'b0;
        else if (rd_accept) seen_reg <= 1'b1;
      end

      assign o_rd_ready = rd_valid_a_reg;
      assign o_rd_hit   = rd_hit_a_reg;
      assign o_rd_data  = !seen_reg    ? '0 :
                          rd_hit_a_reg ? ram_q : MISS_DATA;
    end else begin : g_lat2
      logic              rd_ready_reg;
      logic              rd_hit_reg;
      logic [DATA_W-1:0] rd_data_reg;

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          rd_ready_reg <= 1'b0;
          rd_hit_reg   <= 1'b0;
          rd_data_reg  <= '0;
        end else begin
          rd_ready_reg <= rd_valid_a_reg;
          if (rd_valid_a_reg) begin
            rd_hit_reg  <= rd_hit_a_reg;
            rd_data_reg <= rd_hit_a_reg ? ram_q : MISS_DATA;
          end
        end
      end

      assign o_rd_ready = rd_ready_reg;
      assign o_rd_hit   = rd_hit_reg;
      assign o_rd_data  = rd_data_reg;
    end
  endgenerate

endmodule

// File: tb/tb_s100_ram_window.sv
// Directed bench: a clearing latency-2 board and a non-clearing latency-1 board
// sharing one request bus, each in a 256-word window at 16'h1200.
module tb_s100_ram_window;

  logic        clk = 1'b0;
  logic        rst, rst_nc;
  logic [15:0] wr_addr, rd_addr;
  logic [7:0]  wr_data;
  logic        wr_en, rd_en;

  logic        wr_ack, rd_ready, rd_hit, busy;
  logic [7:0]  rd_data;
  logic        nc_wr_ack, nc_rd_ready, nc_rd_hit, nc_busy;
  logic [7:0]  nc_rd_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  s100_ram_window #(
    .ADDR_W(16), .DATA_W(8), .DEPTH_LOG2(8), .BASE_ADDR(16'h1200),
    .CLEAR_ON_RESET(1'b1), .READ_LATENCY(2), .MISS_DATA(8'hFF)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_enable(wr_en), .o_wr_ack(wr_ack),
    .i_rd_addr(rd_addr), .i_rd_enable(rd_en),
    .o_rd_data(rd_data), .o_rd_ready(rd_ready), .o_rd_hit(rd_hit), .o_busy(busy)
  );

  s100_ram_window #(
    .ADDR_W(16), .DATA_W(8), .DEPTH_LOG2(8), .BASE_ADDR(16'h1200),
    .CLEAR_ON_RESET(1'b0), .READ_LATENCY(1), .MISS_DATA(8'hFF)
  ) dut_nc (
    .i_clk(clk), .i_reset(rst_nc),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_enable(wr_en), .o_wr_ack(nc_wr_ack),
    .i_rd_addr(rd_addr), .i_rd_enable(rd_en),
    .o_rd_data(nc_rd_data), .o_rd_ready(nc_rd_ready), .o_rd_hit(nc_rd_hit), .o_busy(nc_busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_chk(input bit sel_nc, input logic [15:0] addr,
                           input logic [7:0] data, input logic exp_ack);
    wr_addr = addr;
    wr_data = data;
    wr_en   = 1'b1;
    step();
    wr_en = 1'b0;
    $display("write %s @%h = %h", sel_nc ? "nc " : "clr", addr, data);
    check("wr_ack", sel_nc ? nc_wr_ack : wr_ack, exp_ack);
  endtask

  task automatic read_chk(input bit sel_nc, input logic [15:0] addr,
                          input logic [7:0] exp_data, input logic exp_hit);
    rd_addr = addr;
    rd_en   = 1'b1;
    step();
    rd_en = 1'b0;
    if (!sel_nc) begin
      check("rd_ready_early", rd_ready, 1'b0);
      step();
    end
    $display("read  %s @%h -> %h hit=%0d", sel_nc ? "nc " : "clr", addr,
             sel_nc ? nc_rd_data : rd_data, sel_nc ? nc_rd_hit : rd_hit);
    check("rd_ready", sel_nc ? nc_rd_ready : rd_ready, 1'b1);
    check("rd_data",  sel_nc ? nc_rd_data  : rd_data,  exp_data);
    check("rd_hit",   sel_nc ? nc_rd_hit   : rd_hit,   exp_hit);
  endtask

  // Counts cycles with o_busy high, starting in the first cycle out of reset.
  task automatic count_clear(output int n);
    n = 0;
    while (busy && n < 400) begin
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; rst_nc = 1'b1;
    wr_addr = '0; wr_data = '0; wr_en = 1'b0;
    rd_addr = '0; rd_en = 1'b0;

    // 1. reset state and clear sequencing
    repeat (3) step();
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_rd_ready", rd_ready, 1'b0);
    check("rst_rd_hit", rd_hit, 1'b0);
    check("rst_wr_ack", wr_ack, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("nc_rst_busy", nc_busy, 1'b0);
    check("nc_rst_rd_data", nc_rd_data, 8'h00);
    rst = 1'b0; rst_nc = 1'b0;
    count_clear(n);
    check("clear_cycles", n, 256);
    for (int i = 0; i < 256; i++) read_chk(1'b0, 16'h1200 + 16'(i), 8'h00, 1'b1);
    read_chk(1'b0, 16'h0000, 8'hFF, 1'b0);
    read_chk(1'b0, 16'h00FF, 8'hFF, 1'b0);

    // 2. window decode
    write_chk(1'b0, 16'h1234, 8'hA5, 1'b1);
    read_chk(1'b0, 16'h1234, 8'hA5, 1'b1);
    step();
    check("hold_ready", rd_ready, 1'b0);
    check("hold_data", rd_data, 8'hA5);
    check("hold_hit", rd_hit, 1'b1);
    write_chk(1'b0, 16'h1334, 8'h5A, 1'b0);
    read_chk(1'b0, 16'h1334, 8'hFF, 1'b0);
    read_chk(1'b0, 16'h1234, 8'hA5, 1'b1);

    // 3. back-to-back reads, latency 2
    write_chk(1'b0, 16'h1201, 8'h11, 1'b1);
    write_chk(1'b0, 16'h1202, 8'h22, 1'b1);
    write_chk(1'b0, 16'h1203, 8'h33, 1'b1);
    rd_addr = 16'h1201; rd_en = 1'b1;
    step();
    check("pipe_t1_ready", rd_ready, 1'b0);
    rd_addr = 16'h1202;
    step();
    check("pipe_t2_ready", rd_ready, 1'b1);
    check("pipe_t2_data", rd_data, 8'h11);
    rd_addr = 16'h1203;
    step();
    rd_en = 1'b0;
    check("pipe_t3_ready", rd_ready, 1'b1);
    check("pipe_t3_data", rd_data, 8'h22);
    step();
    check("pipe_t4_ready", rd_ready, 1'b1);
    check("pipe_t4_data", rd_data, 8'h33);
    step();
    check("pipe_t5_ready", rd_ready, 1'b0);
    $display("pipe  clr @1201..1203 done");

    // 4. same-cycle read and write to one address
    write_chk(1'b0, 16'h1210, 8'h01, 1'b1);
    wr_addr = 16'h1210; wr_data = 8'h02; wr_en = 1'b1;
    rd_addr = 16'h1210; rd_en = 1'b1;
    step();
    wr_en = 1'b0;
    check("coll_ack", wr_ack, 1'b1);
    check("coll_ready_early", rd_ready, 1'b0);
    step();
    rd_en = 1'b0;
    check("coll_old_ready", rd_ready, 1'b1);
    check("coll_old_data", rd_data, 8'h01);
    step();
    check("coll_new_ready", rd_ready, 1'b1);
    check("coll_new_data", rd_data, 8'h02);
    $display("coll  clr @1210 done");

    // 5. requests ignored while busy, reset mid-clear restarts the sweep
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 120; k++) begin
      wr_en = (k == 100); rd_en = (k == 100);
      wr_addr = 16'h1250; wr_data = 8'h99; rd_addr = 16'h1250;
      if (k >= 101 && k <= 104) begin
        check("busy_ack", wr_ack, 1'b0);
        check("busy_ready", rd_ready, 1'b0);
      end
      if (k == 0 || k == 119) check("busy_mid", busy, 1'b1);
      step();
    end
    wr_en = 1'b0; rd_en = 1'b0;
    rst = 1'b1;
    check("busy_at_reset", busy, 1'b1);
    step();
    check("busy_in_reset", busy, 1'b1);
    rst = 1'b0;
    count_clear(n);
    check("restart_cycles", n, 256);
    read_chk(1'b0, 16'h1250, 8'h00, 1'b1);
    read_chk(1'b0, 16'h1234, 8'h00, 1'b1);

    // 6. board without clear keeps its contents over reset
    write_chk(1'b1, 16'h1205, 8'h77, 1'b1);
    rst_nc = 1'b1;
    step();
    check("nc_busy_r1", nc_busy, 1'b0);
    step();
    check("nc_busy_r2", nc_busy, 1'b0);
    rst_nc = 1'b0;
    step();
    check("nc_busy_after", nc_busy, 1'b0);
    read_chk(1'b1, 16'h1205, 8'h77, 1'b1);
    read_chk(1'b1, 16'h1305, 8'hFF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s100_ram_window.md
Name: s100_ram_window

Overview:
Parametrised S-100 memory board model: a single-port-write / single-port-read synchronous RAM that answers only inside a configurable address window on the 16-bit bus. It has a sequenced clear-on-reset engine, selectable read latency, hit/miss reporting, and explicit ready/ack pulses. It sits behind the S-100 bus controller, and multiple instances tile the address space at different BASE_ADDR values.

Parameters:
ADDR_W, 16, bus address width
DATA_W, 8, data word width
DEPTH_LOG2, 12, log2 of words stored (window size = 2^DEPTH_LOG2); must be <= ADDR_W
BASE_ADDR, 16'h0000, window base; only bits [ADDR_W-1:DEPTH_LOG2] are significant
CLEAR_ON_RESET, 1, 1 = zero every word after reset, 0 = contents untouched by reset
READ_LATENCY, 1, cycles from accepted read to o_rd_ready; legal values 1 or 2
MISS_DATA, 8'hFF, value returned on a read outside the window (floating S-100 bus)

Ports:
i_clk  input  1  clock, all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_wr_addr  input  ADDR_W  write address
i_wr_data  input  DATA_W  write data
i_wr_enable  input  1  write request, one word per cycle
o_wr_ack  output  1  one-cycle pulse: previous-cycle write committed (hit and not busy)
i_rd_addr  input  ADDR_W  read address
i_rd_enable  input  1  read request, one per cycle
o_rd_data  output  DATA_W  read data, valid when o_rd_ready=1, held until next ready
o_rd_ready  output  1  one-cycle pulse: o_rd_data valid
o_rd_hit  output  1  qualifies o_rd_ready: 1 = in window, 0 = miss (data = MISS_DATA)
o_busy  output  1  clear in progress; requests ignored

Behaviour:
- Reset (i_reset=1 at edge) sets: o_rd_data=0, o_rd_ready=0, o_rd_hit=0, o_wr_ack=0, read pipeline flushed, clear counter=0.
- o_busy under reset: 1 if CLEAR_ON_RESET=1, else 0.
- Reset has priority over every other input, including mid-clear; a mid-clear reset restarts the counter at 0.
- FSM states are IDLE and CLEAR.
- Entering CLEAR: the first cycle with i_reset=0 after reset, when CLEAR_ON_RESET=1.
- In CLEAR: writes 0 to word[counter], then increments the counter. Exactly 2^DEPTH_LOG2 clear cycles.
- Leaving CLEAR: o_busy drops on the edge after the last word is written, and the FSM moves to IDLE.
- With CLEAR_ON_RESET=0: the FSM goes straight to IDLE and memory is not modified.
- While o_busy=1: i_wr_enable and i_rd_enable are ignored. No ack, no ready. No queuing.
- Address decode: hit = (addr[ADDR_W-1:DEPTH_LOG2] == BASE_ADDR[ADDR_W-1:DEPTH_LOG2]). The word index is addr[DEPTH_LOG2-1:0].
- When DEPTH_LOG2 = ADDR_W, every address hits.
- Write, IDLE and hit: the word is updated at the edge, and o_wr_ack=1 on the following cycle.
- Write, miss: dropped, and o_wr_ack stays 0.
- Read, IDLE: accepted every cycle the request is present; back-to-back reads give back-to-back ready pulses.
- Read timing: o_rd_ready is 1 exactly READ_LATENCY cycles after the accepting edge.
- Read hit: o_rd_data = stored word, o_rd_hit=1.
- Read miss: o_rd_data = MISS_DATA, o_rd_hit=0, memory not accessed.
- Read ordering: results return in request order.
- Same-cycle read and write to the same hit address: the read returns the OLD word (read-before-write). The new value is visible to reads issued on the next cycle.
- Reads in flight when reset asserts are discarded; no ready pulse.
- o_rd_data and o_rd_hit hold their last values between ready pulses.
- Memory array inferred as block RAM: no reset loop, clear only via the sequencer.
- The sequencer is the only multi-port access; in CLEAR it owns the write port.

Test Plan:
1. Clear sequencing (DEPTH_LOG2=8, CLEAR_ON_RESET=1): hold i_reset 3 cycles, release.
   Required: o_busy=1 for exactly 256 cycles after release. Then read 16'h0000..16'h00FF: every o_rd_data=8'h00, o_rd_hit=1.
2. Window decode (DEPTH_LOG2=8, BASE_ADDR=16'h1200), after clear:
   - write 8'hA5 @16'h1234 -> o_wr_ack pulse next cycle; read @16'h1234 -> 8'hA5, hit=1.
   - write 8'h5A @16'h1334 -> no ack; read @16'h1334 -> 8'hFF, hit=0.
   - read @16'h1234 -> still 8'hA5.
3. Latency (READ_LATENCY=2): reads @16'h1201, @16'h1202, @16'h1203 on consecutive cycles (holding 8'h11, 8'h22, 8'h33).
   Required: o_rd_ready high on cycles t+2, t+3, t+4 with data 8'h11, 8'h22, 8'h33 in order.
4. Collision: word @16'h1210 = 8'h01; same cycle write 8'h02 and read @16'h1210.
   Required: returns 8'h01; a read on the next cycle returns 8'h02.
5. Busy / mid-clear reset: during clear cycle 100, issue a write and a read -> no ack, no ready.
   Assert reset at cycle 120 -> o_busy stays 1, and the full 256-cycle clear restarts from 0 after release.
6. CLEAR_ON_RESET=0: write 8'h77 @16'h1205, pulse reset -> o_busy never 1; read @16'h1205 returns 8'h77.
